// File: rtl/receiver_pkg.sv
// receiver_pkg: shared constants and state type for the serial frame receiver
package receiver_pkg;
   localparam int DATA_W = 8;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] SFD = 8'hAB;
   typedef enum logic {HUNT, RECEIVE} state_t;
endpackage

// File: rtl/receiver_sfd_detector.sv
// sfd_detector: sliding-window start-of-frame delimiter matcher
//   clk, reset (async active-low), en (shift rx into window), clr (empty the window),
//   rx (serial bit), match (window including current rx equals SFD)
module sfd_detector
   import receiver_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  logic rx,
   output logic match
);
   // Window bit 0 falls out on the next shift, so only the upper 7 bits are kept.
   logic [DATA_W-2:0] hist;
   logic [DATA_W-1:0] win;
   assign win = {rx, hist};
   assign match = win == SFD;
   always_ff @(posedge clk or negedge reset)
      if (!reset) hist <= '0;
      else if (clr) hist <= '0;
      else if (en) hist <= win[DATA_W-1:1];
endmodule

// File: rtl/receiver.sv
// receiver: serial frame receiver, hunts SFD then captures one LSB-first byte
//   clk, reset (async active-low), rx (serial in, one bit per clk),
//   rec_complete (one-cycle pulse with a new byte), dout (last received byte)
module receiver
   import receiver_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic              rec_complete,
   output logic [DATA_W-1:0] dout
);
   state_t            state;
   logic [DATA_W-2:0] data_hist;
   logic [CNT_W-1:0]  cnt;
   logic              match;
   logic              hunt;
   logic              last;
   assign hunt = state == HUNT;
   assign last = state == RECEIVE && cnt == CNT_W'(DATA_W - 1);
   // Window is frozen while receiving so payload bits never form an SFD, and emptied at frame end.
   sfd_detector u_sfd (
      .clk   (clk),
      .reset (reset),
      .en    (hunt),
      .clr   (last),
      .rx    (rx),
      .match (match)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state        <= HUNT;
         data_hist    <= '0;
         cnt          <= '0;
         dout         <= '0;
         rec_complete <= 1'b0;
      end else begin
         rec_complete <= last;
         if (hunt) begin
            if (match) begin
               state <= RECEIVE;
               cnt   <= '0;
            end
         end else begin
            data_hist <= {rx, data_hist[DATA_W-2:1]};
            cnt       <= cnt + 1'b1;
            if (last) begin
               dout  <= {rx, data_hist};
               state <= HUNT;
            end
         end
      end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed self-checking bench for receiver
module tb_receiver;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b0;
   logic       rec_complete;
   logic [7:0] dout;
   int         n_checks = 0;
   int         n_fail = 0;
   int         pulses = 0;
   int         p0;

   receiver dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .rec_complete (rec_complete),
      .dout         (dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk) rx = b;
      @(posedge clk);
      #1;
      if (rec_complete) pulses++;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   initial begin
      repeat (10) @(posedge clk);
      #1;
      check("reset_dout", dout, 8'h00);
      check("reset_rec", rec_complete, 1'b0);
      @(negedge clk) reset = 1'b1;

      // first frame: SFD + 0x93
      send_byte(8'hAB);
      check("f1_no_early_pulse", pulses, 0);
      check("f1_dout_hold", dout, 8'h00);
      send_byte(8'h93);
      check("f1_rec", rec_complete, 1'b1);
      check("f1_dout", dout, 8'h93);
      check("f1_pulses", pulses, 1);

      // back-to-back SFD starting while rec_complete is high
      send_bit(1'b1);
      check("b2b_pulse_width", rec_complete, 1'b0);
      check("b2b_dout_hold", dout, 8'h93);
      for (int i = 1; i < 8; i++) send_bit(i != 2 && i != 4 && i != 6);
      send_byte(8'h00);
      check("b2b_rec", rec_complete, 1'b1);
      check("b2b_dout", dout, 8'h00);
      check("b2b_pulses", pulses, 2);

      // preamble of alternating bits then SFD + 0xA5
      for (int i = 0; i < 13; i++) send_bit(i % 2 == 0);
      check("pre_no_false", pulses, 2);
      send_byte(8'hAB);
      send_byte(8'hA5);
      check("pre_dout", dout, 8'hA5);
      check("pre_pulses", pulses, 3);

      // payload equal to SFD must not retrigger
      send_byte(8'hAB);
      send_byte(8'hAB);
      check("pay_dout", dout, 8'hAB);
      check("pay_pulses", pulses, 4);
      for (int i = 0; i < 20; i++) send_bit(1'b0);
      check("pay_no_retrigger", pulses, 4);

      // near miss patterns
      send_byte(8'hAA);
      send_byte(8'h2B);
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      check("near_pulses", pulses, 4);
      check("near_dout", dout, 8'hAB);

      // reset mid-frame
      send_byte(8'hAB);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      p0 = pulses;
      #2 reset = 1'b0;
      #1;
      check("mid_rst_dout", dout, 8'h00);
      check("mid_rst_rec", rec_complete, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (rec_complete) pulses++;
      end
      @(negedge clk) reset = 1'b1;
      rx = 1'b1;
      for (int i = 0; i < 6; i++) send_bit(1'b0);
      check("mid_rst_no_pulse", pulses, p0);
      check("mid_rst_dout_after", dout, 8'h00);
      send_byte(8'hAB);
      send_byte(8'h3C);
      check("rec_after_rst_dout", dout, 8'h3C);
      check("rec_after_rst_rec", rec_complete, 1'b1);
      check("rec_after_rst_pulses", pulses, p0 + 1);
      send_bit(1'b0);
      check("final_pulse_end", rec_complete, 1'b0);
      check("final_dout_hold", dout, 8'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- Serial frame receiver. Samples one bit of `rx` per `clk` rising edge and hunts for an 8-bit start-of-frame delimiter (SFD).
- After the SFD it captures the next 8 bits LSB-first, presents the byte on `dout` and pulses `rec_complete`.
- Sits at the serial ingress of the hub, ahead of the byte-level packet logic.

Parameters:
- DATA_W, 8, payload width in bits, also the SFD length.
- SFD, 8'b10101011 (8'hAB), delimiter value, transmitted LSB-first (on-wire order 1,1,0,1,0,1,0,1).

Ports:
- clk  input  1  system clock; `rx` sampled on rising edge, one bit per cycle.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  serial data in, LSB-first, one bit per clk.
- rec_complete  output  1  one-cycle pulse, high when `dout` holds a newly received byte.
- dout  output  DATA_W  last received payload byte.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=HUNT; hunt shift register=0; data shift register=0; bit counter=0.
  - dout=0; rec_complete=0.
  - Deassertion takes effect at the next clk edge.
- Bit order: each sampled bit enters at the MSB and the register shifts right. After 8 bits the first-received bit sits at bit 0.
- HUNT state:
  - Every clk edge: hunt_reg <= {rx, hunt_reg[7:1]}.
  - Detection uses a sliding window, so any alignment is found, including after arbitrary preamble bits.
  - When the next value {rx, hunt_reg[7:1]} equals SFD, go to RECEIVE at that edge. The bit counter is cleared.
  - The SFD match therefore completes on the edge that samples the 8th SFD bit.
- RECEIVE state:
  - Every clk edge: data_reg <= {rx, data_reg[7:1]}; counter increments.
  - On the edge sampling the 8th data bit (counter==7):
    - dout <= {rx, data_reg[7:1]};
    - rec_complete <= 1;
    - hunt_reg <= 0;
    - state <= HUNT.
  - The hunt register is not updated during RECEIVE, so payload bits never count toward SFD detection.
  - After a frame, SFD search restarts from an empty window.
- rec_complete:
  - Registered. High for exactly the one cycle following the edge that sampled the last payload bit; low otherwise.
  - Latency: 16 clk edges from the first SFD bit to rec_complete rising, when SFD and data are back-to-back.
- dout:
  - Registered. Updated only on completion and holds its value between frames.
  - Never shows partial bytes.
- Back-to-back frames:
  - An SFD may start on the very next clk edge after the last payload bit, i.e. in the same cycle rec_complete is high.
  - It must be detected.
- Near-miss patterns: no action, hunting continues.
- Reset mid-frame: the frame is discarded, no rec_complete pulse, and dout returns to 0.
- Fully synchronous except the asynchronous reset. No backpressure: the consumer must take `dout` while rec_complete is high, or any time before the next completion.

Decomposition:
- Shared package: DATA_W and SFD constants, state enum {HUNT, RECEIVE}.
- One optional sub-module, `sfd_detector`: sliding 8-bit shift register plus comparator, with a clear input and a match output.
- Data capture, counter and FSM stay in `receiver`.

Test Plan:
- Reset then frame: hold `reset`=0 for 10 cycles with rx=0, release. Send SFD (1,1,0,1,0,1,0,1) then 0x93 (1,1,0,0,1,0,0,1). Expect dout=0x93 and rec_complete high for exactly 1 cycle, after the 16th bit edge.
- Back-to-back: immediately send SFD again, then 8 zeros. Expect a second rec_complete pulse with dout=0x00; dout holds 0x93 until then.
- Preamble/alignment: send 0x55 pattern bits (1,0,1,0,...) for 13 cycles, then SFD+0xA5. Expect a single pulse with dout=0xA5 and no earlier false trigger.
- Payload containing SFD: SFD followed by payload 0xAB, then rx=0 for 20 cycles. Expect exactly one pulse with dout=0xAB and no second detection.
- Near miss: send 0xAA and 0x2B LSB-first with no valid SFD. Expect rec_complete to stay 0 and dout unchanged.
- Reset mid-frame: assert `reset`=0 after SFD plus 4 data bits. Expect dout=0 and no pulse; a following clean SFD+0x3C yields dout=0x3C.
